seq_priority_encoder_8to3: RTL

SEQ_PRIORITY_ENCODER_8TO3 -- requirements
Module: seq_priority_encoder_8to3

---
 rtl/seq_priority_encoder_8to3.sv | 93 +++++++++
 1 files changed

// File: rtl/seq_priority_encoder_8to3.sv
// rtl/seq_priority_encoder_8to3.sv - sequential 8-to-3 priority encoder emitting one beat per set bit
module seq_priority_encoder_8to3 #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_code,
  output logic       out_last,
  output logic       out_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    ZERO = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pending_q, pending_d;

  logic [2:0] sel_code;
  logic [7:0] sel_mask;
  logic       single_left;

  // Scan toward the priority end so the final assignment is the winning bit.
  always_comb begin
    sel_code = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (MSB_FIRST) begin
        if (pending_q[i]) sel_code = 3'(i);
      end else begin
        if (pending_q[7-i]) sel_code = 3'(7 - i);
      end
    end
  end

  assign sel_mask    = 8'b0000_0001 << sel_code;
  assign single_left = (pending_q != 8'h00) && ((pending_q & (pending_q - 8'd1)) == 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_code  = 3'd0;
    out_last  = 1'b0;
    out_zero  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          pending_d = in_data;
          state_d   = (in_data != 8'h00) ? EMIT : ZERO;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        out_code  = sel_code;
        out_last  = single_left;
        if (out_ready) begin
          pending_d = pending_q & ~sel_mask;
          if (single_left) state_d = IDLE;
        end
      end
      ZERO: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_zero  = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        pending_d = 8'h00;
      end
    endcase
  end

endmodule
